// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit full adder built from two half adders and an OR; the serial adder's only arithmetic.
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0, c0, c1;

  Half_Adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  Half_Adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  // The two half-adder carries can never both be set, so OR completes the carry.
  assign cout = c0 | c1;
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB first, with a start/busy/done handshake.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sum_shifted;

  full_adder_cell u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
  assign sum_shifted = {fa_s, sum_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    cout_d   = cout_q;
    case (state_q)
      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = sum_shifted;
        carry_d  = fa_c;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          s_d     = sum_shifted;
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE, DONE and the unused encoding all accept a new request.
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized self-checking bench for bit_serial_adder against a plain a+b+cin model.
module tb_bit_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] s;
  int checks = 0;
  int failures = 0;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Drives one request, scrambles operands during RUN, waits for done (bounded).
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output logic [8:0] res, output int edges, output logic ok);
    @(negedge clk); a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); edges = 1;
    @(negedge clk); start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); edges++;
      @(negedge clk);
    end
    res = {cout, s};
    $display("add a=%02h b=%02h cin=%0d -> cout=%0d s=%02h edges=%0d", ta, tb_, tc, res[8], res[7:0], edges);
  endtask

  task automatic test_reset();
    #12;
    checks += 4;
    if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (s !== 8'h00)    begin failures++; $display("FAIL reset_s got=%02h exp=00", s); end
    if (cout !== 1'b0)  begin failures++; $display("FAIL reset_cout got=%0b exp=0", cout); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [8:0] res; int edges; logic ok;
    do_add(8'h3C, 8'h42, 1'b0, res, edges, ok);
    checks += 3;
    if (!ok)          begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    if (edges != 9)   begin failures++; $display("FAIL basic_latency got=%0d exp=9", edges); end
    if (res !== 9'h07E) begin failures++; $display("FAIL basic_sum got=%03h exp=07E", res); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%0b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_carry();
    logic [8:0] res; int edges; logic ok;
    do_add(8'hFF, 8'h01, 1'b0, res, edges, ok);
    checks++;
    if (!ok || res !== 9'h100) begin failures++; $display("FAIL carry_ff01 got=%03h ok=%0b exp=100", res, ok); end
    do_add(8'hA5, 8'h5A, 1'b1, res, edges, ok);
    checks++;
    if (!ok || res !== 9'h100) begin failures++; $display("FAIL carry_a55a got=%03h ok=%0b exp=100", res, ok); end
  endtask

  task automatic test_ignore_start();
    int pulses = 0; logic drop = 1'b0; logic [8:0] res = '0;
    @(negedge clk); a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (!busy) drop = 1'b1;
    end
    a = 8'hFF; b = 8'($urandom); cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) res = {cout, s};
      end else if (pulses == 0 && !busy) drop = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    $display("ignore_start a=11 b=22 -> s=%02h cout=%0d pulses=%0d", res[7:0], res[8], pulses);
    checks += 3;
    if (pulses != 1)    begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    if (res !== 9'h033) begin failures++; $display("FAIL ignore_sum got=%03h exp=033", res); end
    if (drop)           begin failures++; $display("FAIL ignore_busy_drop got=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    logic ok = 1'b0; logic held = 1'b1; logic [8:0] res;
    @(negedge clk); a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); a = 8'h01; b = 8'h01; cin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk); @(negedge clk);
    end
    res = {cout, s};
    checks++;
    if (!ok || res !== 9'h030) begin failures++; $display("FAIL b2b_first got=%03h ok=%0b exp=030", res, ok); end
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%0b exp=1", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL b2b_restart_done got=%0b exp=0", done); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      if ({cout, s} !== 9'h030) held = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    res = {cout, s};
    $display("back_to_back 10+20 then 01+01 -> s=%02h cout=%0d", res[7:0], res[8]);
    checks += 2;
    if (!held)                 begin failures++; $display("FAIL b2b_hold got=changed exp=030_held"); end
    if (!ok || res !== 9'h002) begin failures++; $display("FAIL b2b_second got=%03h ok=%0b exp=002", res, ok); end
  endtask

  task automatic test_async_reset();
    int pulses = 0; logic [8:0] res; int edges; logic ok;
    @(negedge clk); a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async_reset busy=%0b done=%0b s=%02h cout=%0b", busy, done, s, cout);
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%0b exp=0", done); end
    if (s !== 8'h00)   begin failures++; $display("FAIL areset_s got=%02h exp=00", s); end
    if (cout !== 1'b0) begin failures++; $display("FAIL areset_cout got=%0b exp=0", cout); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) pulses++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL areset_no_done got=%0d exp=0", pulses); end
    do_add(8'h5C, 8'h27, 1'b1, res, edges, ok);
    checks++;
    if (!ok || res !== model(8'h5C, 8'h27, 1'b1))
      begin failures++; $display("FAIL areset_fresh got=%03h exp=%03h", res, model(8'h5C, 8'h27, 1'b1)); end
  endtask

  task automatic test_corners();
    logic [7:0] vals [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [8:0] res; int edges; logic ok;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int c = 0; c < 2; c++) begin
          do_add(vals[i], vals[j], 1'(c), res, edges, ok);
          checks++;
          if (!ok || res !== model(vals[i], vals[j], 1'(c)))
            begin failures++; $display("FAIL corner_%02h_%02h_%0d got=%03h exp=%03h", vals[i], vals[j], c, res, model(vals[i], vals[j], 1'(c))); end
        end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb; logic rc; logic [8:0] res; int edges; logic ok;
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_add(ra, rb, rc, res, edges, ok);
      checks += 2;
      if (!ok || res !== model(ra, rb, rc))
        begin failures++; $display("FAIL random_sum got=%03h exp=%03h", res, model(ra, rb, rc)); end
      if (edges != 9) begin failures++; $display("FAIL random_latency got=%0d exp=9", edges); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
